// File: rtl/mouse_cursor_tracker_pkg.sv
// Shared PS/2 mouse definitions: FSM encodings, status-byte layout and a
// reset-value helper. Imported by the tracker and by the PS/2 stage.
package mouse_cursor_tracker_pkg;

  localparam int CURSOR_W = 10;
  localparam int STATE_W  = 3;

  // FSM encodings (plain constants so older tools and checkers can bind them)
  localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] S_LATCH  = 3'd1;
  localparam logic [STATE_W-1:0] S_CHECK  = 3'd2;
  localparam logic [STATE_W-1:0] S_CALC_X = 3'd3;
  localparam logic [STATE_W-1:0] S_CALC_Y = 3'd4;
  localparam logic [STATE_W-1:0] S_COMMIT = 3'd5;

  // PS/2 status byte bit positions
  localparam int BIT_L   = 0;
  localparam int BIT_R   = 1;
  localparam int BIT_M   = 2;
  localparam int BIT_ONE = 3;
  localparam int BIT_XS  = 4;
  localparam int BIT_YS  = 5;
  localparam int BIT_XO  = 6;
  localparam int BIT_YO  = 7;

  // Status byte as a struct, MSB first, matching the bit positions above
  typedef struct packed {
    logic y_ovf;
    logic x_ovf;
    logic y_sign;
    logic x_sign;
    logic always1;
    logic btn_m;
    logic btn_r;
    logic btn_l;
  } ps2_status_t;

  // Reset value for a cursor axis: an out-of-range init is pulled to the edge
  function automatic logic [CURSOR_W-1:0] clamp_init(input int value, input int max_v);
    return (value > max_v) ? CURSOR_W'(max_v) : CURSOR_W'(value);
  endfunction

endpackage

// File: rtl/mouse_cursor_tracker_if.sv
// Bus between the PS/2 packet stage (master) and the cursor tracker (slave).
//
// Handshake: data_tx is a level pulse, several clocks wide, raised by the
// PS/2 stage once status_pck_1/xm_pck_2/ym_pck_3 are stable; the bytes must
// stay stable until the tracker has latched them (two clocks after the
// synchronized rising edge). There is no ready: the tracker queues at most
// one extra packet and silently drops further ones. pkt_valid and sync_err
// are single-cycle result pulses and are never high together.
interface mouse_cursor_tracker_if;
  import mouse_cursor_tracker_pkg::*;

  logic                data_tx;
  logic [7:0]          status_pck_1;
  logic [7:0]          xm_pck_2;
  logic [7:0]          ym_pck_3;
  logic [CURSOR_W-1:0] cursor_x;
  logic [CURSOR_W-1:0] cursor_y;
  logic                btn_left;
  logic                btn_right;
  logic                btn_middle;
  logic                pkt_valid;
  logic                sync_err;
  logic [7:0]          err_count;
  logic [STATE_W-1:0]  state_dbg;

  modport master (
    output data_tx, status_pck_1, xm_pck_2, ym_pck_3,
    input  cursor_x, cursor_y, btn_left, btn_right, btn_middle,
           pkt_valid, sync_err, err_count, state_dbg
  );

  modport slave (
    input  data_tx, status_pck_1, xm_pck_2, ym_pck_3,
    output cursor_x, cursor_y, btn_left, btn_right, btn_middle,
           pkt_valid, sync_err, err_count, state_dbg
  );
endinterface

// File: rtl/mouse_axis_clamp.sv
// One cursor axis: decode the 9-bit PS/2 delta (with overflow saturation),
// add or subtract it from the current position, clamp to 0..MAX.
module mouse_axis_clamp
  import mouse_cursor_tracker_pkg::*;
#(
  parameter int   MAX = 639,
  parameter logic SUB = 1'b0
) (
  input  logic [CURSOR_W-1:0] cur_i,
  input  logic [7:0]          mov_i,
  input  logic                sign_i,
  input  logic                ovf_i,
  output logic [CURSOR_W-1:0] nxt_o
);

  localparam logic signed [10:0] MAX_S = 11'(MAX);

  logic signed [10:0] delta;
  logic signed [10:0] cur_s;
  logic signed [10:0] sum;

  // Delta decode, signed add/subtract and clamp to the legal range
  always_comb begin
    if (ovf_i) begin
      delta = sign_i ? 11'sh700 : 11'sh0FF;  // -256 or +255
    end else begin
      delta = $signed({{2{sign_i}}, sign_i, mov_i});
    end
    cur_s = $signed({1'b0, cur_i});
    sum   = SUB ? (cur_s - delta) : (cur_s + delta);
    if (sum[10]) begin
      nxt_o = '0;
    end else if (sum > MAX_S) begin
      nxt_o = CURSOR_W'(MAX);
    end else begin
      nxt_o = sum[CURSOR_W-1:0];
    end
  end

endmodule

// File: rtl/mouse_cursor_tracker.sv
// PS/2 mouse cursor tracker: synchronizes the packet-ready pulse, validates
// the status byte, and moves a clamped cursor through a fixed six-state pass.
module mouse_cursor_tracker
  import mouse_cursor_tracker_pkg::*;
#(
  parameter int X_MAX  = 639,
  parameter int Y_MAX  = 479,
  parameter int X_INIT = 320,
  parameter int Y_INIT = 240
) (
  input  logic                    qzt_clk,
  input  logic                    rst,
  mouse_cursor_tracker_if.slave   bus
);

  localparam logic [CURSOR_W-1:0] X_RST = clamp_init(X_INIT, X_MAX);
  localparam logic [CURSOR_W-1:0] Y_RST = clamp_init(Y_INIT, Y_MAX);

  logic                sync1_q, sync2_q, sync_prev_q;
  logic                edge_det;
  logic [STATE_W-1:0]  state_q, state_d;
  logic                pending_q, pending_d;
  ps2_status_t         status_q;
  logic [7:0]          xm_q, ym_q;
  logic [CURSOR_W-1:0] new_x_q, new_y_q;
  logic [CURSOR_W-1:0] calc_x, calc_y;
  logic [CURSOR_W-1:0] cursor_x_q, cursor_y_q;
  logic [2:0]          btn_q;
  logic                pkt_valid_q, sync_err_q;
  logic [7:0]          err_count_q;
  logic                bad_pkt;

  // Two-flop synchronizer plus one history flop for rising-edge detection
  always_ff @(posedge qzt_clk) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync_prev_q <= 1'b0;
    end else begin
      sync1_q     <= bus.data_tx;
      sync2_q     <= sync1_q;
      sync_prev_q <= sync2_q;
    end
  end

  assign edge_det = sync2_q & ~sync_prev_q;
  assign bad_pkt  = (state_q == S_CHECK) && !status_q.always1;

  // Next-state and pending-flag logic
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      S_IDLE: begin
        if (edge_det || pending_q) begin
          state_d   = S_LATCH;
          // Serving the queued packet: a coinciding edge becomes the new queued one
          pending_d = pending_q & edge_det;
        end
      end
      S_LATCH:  state_d = S_CHECK;
      S_CHECK:  state_d = status_q.always1 ? S_CALC_X : S_IDLE;
      S_CALC_X: state_d = S_CALC_Y;
      S_CALC_Y: state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // One-deep queue; an edge while already pending is dropped
    if ((state_q != S_IDLE) && edge_det) begin
      pending_d = 1'b1;
    end
  end

  // FSM state and pending flag registers
  always_ff @(posedge qzt_clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  // Capture the three packet bytes; later states only use these copies
  always_ff @(posedge qzt_clk) begin
    if (rst) begin
      status_q <= '0;
      xm_q     <= '0;
      ym_q     <= '0;
    end else if (state_q == S_LATCH) begin
      status_q <= ps2_status_t'(bus.status_pck_1);
      xm_q     <= bus.xm_pck_2;
      ym_q     <= bus.ym_pck_3;
    end
  end

  mouse_axis_clamp #(.MAX(X_MAX), .SUB(1'b0)) u_axis_x (
    .cur_i  (cursor_x_q),
    .mov_i  (xm_q),
    .sign_i (status_q.x_sign),
    .ovf_i  (status_q.x_ovf),
    .nxt_o  (calc_x)
  );

  // Y is positive-up on the wire but row 0 is the top, hence subtract
  mouse_axis_clamp #(.MAX(Y_MAX), .SUB(1'b1)) u_axis_y (
    .cur_i  (cursor_y_q),
    .mov_i  (ym_q),
    .sign_i (status_q.y_sign),
    .ovf_i  (status_q.y_ovf),
    .nxt_o  (calc_y)
  );

  // Hold each axis result until COMMIT publishes both together
  always_ff @(posedge qzt_clk) begin
    if (rst) begin
      new_x_q <= X_RST;
      new_y_q <= Y_RST;
    end else begin
      if (state_q == S_CALC_X) new_x_q <= calc_x;
      if (state_q == S_CALC_Y) new_y_q <= calc_y;
    end
  end

  // Visible outputs, result pulses and the saturating error counter
  always_ff @(posedge qzt_clk) begin
    if (rst) begin
      cursor_x_q  <= X_RST;
      cursor_y_q  <= Y_RST;
      btn_q       <= '0;
      pkt_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      pkt_valid_q <= (state_q == S_COMMIT);
      sync_err_q  <= bad_pkt;
      if (state_q == S_COMMIT) begin
        cursor_x_q <= new_x_q;
        cursor_y_q <= new_y_q;
        btn_q      <= {status_q.btn_m, status_q.btn_r, status_q.btn_l};
      end
      if (bad_pkt && (err_count_q != 8'hFF)) begin
        err_count_q <= err_count_q + 8'd1;
      end
    end
  end

  assign bus.cursor_x   = cursor_x_q;
  assign bus.cursor_y   = cursor_y_q;
  assign bus.btn_left   = btn_q[0];
  assign bus.btn_right  = btn_q[1];
  assign bus.btn_middle = btn_q[2];
  assign bus.pkt_valid  = pkt_valid_q;
  assign bus.sync_err   = sync_err_q;
  assign bus.err_count  = err_count_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// Testbench for mouse_cursor_tracker: directed spec scenarios followed by
// random packets, all checked against a plain-arithmetic cursor model.
module tb_mouse_cursor_tracker;
  import mouse_cursor_tracker_pkg::*;

  logic qzt_clk = 1'b0;
  logic rst     = 1'b1;

  mouse_cursor_tracker_if bus  ();
  mouse_cursor_tracker_if bus2 ();

  mouse_cursor_tracker dut (
    .qzt_clk (qzt_clk),
    .rst     (rst),
    .bus     (bus)
  );

  // Second instance checks that out-of-range init values are clamped
  mouse_cursor_tracker #(.X_INIT(700), .Y_INIT(500)) dut_clamp (
    .qzt_clk (qzt_clk),
    .rst     (rst),
    .bus     (bus2)
  );

  // Clock
  always #5 qzt_clk = ~qzt_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int       m_x, m_y, m_err;
  bit [2:0] m_btn;

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int axis_model(int cur, int mov, bit sgn, bit ovf, bit sub, int max_v);
    int d, n;
    if (ovf) d = sgn ? -256 : 255;
    else     d = sgn ? mov - 256 : mov;
    n = sub ? cur - d : cur + d;
    if (n < 0) n = 0;
    else if (n > max_v) n = max_v;
    return n;
  endfunction

  task automatic model_reset();
    m_x = 320; m_y = 240; m_btn = 3'b000; m_err = 0;
  endtask

  task automatic model_packet(input logic [7:0] s, input logic [7:0] x, input logic [7:0] y);
    if (!s[3]) begin
      if (m_err < 255) m_err++;
    end else begin
      m_x   = axis_model(m_x, int'(x), s[4], s[6], 1'b0, 639);
      m_y   = axis_model(m_y, int'(y), s[5], s[7], 1'b1, 479);
      m_btn = s[2:0];
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_x"},   32'(bus.cursor_x), 32'(m_x));
    check({tag, "_y"},   32'(bus.cursor_y), 32'(m_y));
    check({tag, "_btn"}, 32'({bus.btn_middle, bus.btn_right, bus.btn_left}), 32'(m_btn));
    check({tag, "_err"}, 32'(bus.err_count), 32'(m_err));
  endtask

  // Drive: reset for two cycles, inputs quiet
  task automatic do_reset();
    @(posedge qzt_clk); #1;
    rst = 1'b1;
    bus.data_tx = 1'b0;
    repeat (2) @(posedge qzt_clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // Drive one packet (data_tx high two cycles) and watch 16 cycles
  task automatic send_packet(input string tag, input logic [7:0] s,
                             input logic [7:0] x, input logic [7:0] y);
    int pv_n, se_n, both_n, pv_cyc;
    bit ok;
    pv_n = 0; se_n = 0; both_n = 0; pv_cyc = -1;
    ok = s[3];
    bus.status_pck_1 = s;
    bus.xm_pck_2     = x;
    bus.ym_pck_3     = y;
    bus.data_tx      = 1'b1;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(posedge qzt_clk); #1;
      if (cyc == 2) bus.data_tx = 1'b0;
      if (bus.pkt_valid) begin pv_n++; pv_cyc = cyc; end
      if (bus.sync_err) se_n++;
      if (bus.pkt_valid && bus.sync_err) both_n++;
    end
    model_packet(s, x, y);
    check({tag, "_pv_count"}, 32'(pv_n), ok ? 32'd1 : 32'd0);
    if (ok) check({tag, "_pv_latency"}, 32'(pv_cyc), 32'd8);
    check({tag, "_se_count"}, 32'(se_n), ok ? 32'd0 : 32'd1);
    check({tag, "_pv_se_overlap"}, 32'(both_n), 32'd0);
    check_outputs(tag);
  endtask

  initial begin
    int pv_n, se_n, e1x, e1y;
    int pv_q[$];
    logic [7:0] s, x, y;

    bus.data_tx = 1'b0; bus.status_pck_1 = '0; bus.xm_pck_2 = '0; bus.ym_pck_3 = '0;
    bus2.data_tx = 1'b0; bus2.status_pck_1 = '0; bus2.xm_pck_2 = '0; bus2.ym_pck_3 = '0;

    // Reset state
    do_reset();
    check("rst_pv", 32'(bus.pkt_valid), 32'd0);
    check("rst_se", 32'(bus.sync_err), 32'd0);
    check("rst_state", 32'(bus.state_dbg), 32'(S_IDLE));
    check_outputs("rst");
    check("clampinit_x", 32'(bus2.cursor_x), 32'd639);
    check("clampinit_y", 32'(bus2.cursor_y), 32'd479);

    // Directed packets
    send_packet("pkt_left",   8'h09, 8'h0A, 8'h05);
    check("pkt_left_x_abs", 32'(bus.cursor_x), 32'd330);
    send_packet("pkt_neg",    8'h38, 8'hF6, 8'hFB);
    send_packet("pkt_xovf",   8'h48, 8'h00, 8'h00);
    send_packet("pkt_to_edge", 8'h08, 8'h37, 8'hEB);
    check("edge_pos_x", 32'(bus.cursor_x), 32'd630);
    check("edge_pos_y", 32'(bus.cursor_y), 32'd5);
    send_packet("pkt_clamp",  8'h08, 8'h14, 8'h0A);
    check("clamp_abs_x", 32'(bus.cursor_x), 32'd639);
    check("clamp_abs_y", 32'(bus.cursor_y), 32'd0);
    send_packet("pkt_bad",    8'h01, 8'h10, 8'h10);

    // Error counter saturation
    for (int i = 0; i < 256; i++) begin
      s = 8'($urandom_range(0, 255));
      s[3] = 1'b0;
      send_packet("pkt_bad_sat", s, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    check("err_saturated", 32'(bus.err_count), 32'd255);

    // Queued packet: second edge during CALC_X, third edge dropped
    do_reset();
    model_packet(8'h58, 8'h00, 8'h00);
    e1x = m_x; e1y = m_y;
    pv_q.delete();
    se_n = 0;
    bus.status_pck_1 = 8'h58; bus.xm_pck_2 = 8'h00; bus.ym_pck_3 = 8'h00;
    bus.data_tx = 1'b1;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      @(posedge qzt_clk); #1;
      case (cyc)
        2: bus.data_tx = 1'b0;
        3: bus.data_tx = 1'b1;
        4: begin
          bus.data_tx = 1'b0;
          bus.status_pck_1 = 8'h0A; bus.xm_pck_2 = 8'h05; bus.ym_pck_3 = 8'h03;
        end
        5: bus.data_tx = 1'b1;
        7: bus.data_tx = 1'b0;
        default: ;
      endcase
      if (bus.pkt_valid) pv_q.push_back(cyc);
      if (bus.sync_err) se_n++;
      if (cyc == 8) begin
        check("queue_first_x", 32'(bus.cursor_x), 32'(e1x));
        check("queue_first_y", 32'(bus.cursor_y), 32'(e1y));
      end
    end
    model_packet(8'h0A, 8'h05, 8'h03);
    check("queue_first_abs_x", 32'(e1x), 32'd64);
    check("queue_pv_count", 32'(pv_q.size()), 32'd2);
    if (pv_q.size() == 2) begin
      check("queue_pv0_cyc", 32'(pv_q[0]), 32'd8);
      check("queue_pv1_cyc", 32'(pv_q[1]), 32'd14);
    end
    check("queue_se_count", 32'(se_n), 32'd0);
    check_outputs("queue_second");

    // Reset mid-packet (during CALC_X) aborts it
    pv_n = 0; se_n = 0;
    bus.status_pck_1 = 8'h0B; bus.xm_pck_2 = 8'h20; bus.ym_pck_3 = 8'h20;
    bus.data_tx = 1'b1;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(posedge qzt_clk); #1;
      if (cyc == 2) bus.data_tx = 1'b0;
      if (cyc == 5) rst = 1'b1;
      if (cyc == 6) rst = 1'b0;
      if (bus.pkt_valid) pv_n++;
      if (bus.sync_err) se_n++;
    end
    model_reset();
    check("midrst_pv", 32'(pv_n), 32'd0);
    check("midrst_se", 32'(pv_n + se_n), 32'd0);
    check_outputs("midrst");

    // Edge already in the synchronizer when reset hits is discarded
    pv_n = 0;
    bus.status_pck_1 = 8'h0F; bus.xm_pck_2 = 8'h40; bus.ym_pck_3 = 8'h40;
    bus.data_tx = 1'b1;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(posedge qzt_clk); #1;
      if (cyc == 1) rst = 1'b1;
      if (cyc == 2) begin rst = 1'b0; bus.data_tx = 1'b0; end
      if (bus.pkt_valid) pv_n++;
    end
    check("syncrst_pv", 32'(pv_n), 32'd0);
    check_outputs("syncrst");

    // Random packets against the model
    for (int i = 0; i < 60; i++) begin
      s = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 4) != 0) s[3] = 1'b1;
      x = 8'($urandom_range(0, 255));
      y = 8'($urandom_range(0, 255));
      send_packet("rand", s, x, y);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
